// File: rtl/core_types_pkg.sv
// Shared rename-stage types: snapshot layout and checkpoint sizing.
package core_types_pkg;

    localparam int AR_COUNT             = 32;
    localparam int LOG_PR_COUNT         = 6;
    localparam int CHECKPOINT_COUNT     = 8;
    localparam int LOG_CHECKPOINT_COUNT = $clog2(CHECKPOINT_COUNT);

    typedef logic [AR_COUNT-1:0][LOG_PR_COUNT-1:0] map_table_snapshot_t;

endpackage

// File: rtl/checkpoint_ptr_ctrl.sv
// Head/tail pointers with wrap bits for the checkpoint ring,
// including occupancy and the restore tail rewind.
module checkpoint_ptr_ctrl #(
    parameter int LW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_save,
    input  logic          i_free,
    input  logic          i_restore,
    input  logic [LW-1:0] i_restore_idx,
    output logic [LW-1:0] o_head_idx,
    output logic [LW-1:0] o_tail_idx,
    output logic [LW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [LW:0] r_head;
    logic [LW:0] r_tail;
    logic        w_do_free;
    logic        w_wrap;

    assign o_head_idx = r_head[LW-1:0];
    assign o_tail_idx = r_tail[LW-1:0];
    assign o_empty    = (r_head == r_tail);
    assign o_full     = (r_head[LW] != r_tail[LW]) &&
                        (r_head[LW-1:0] == r_tail[LW-1:0]);
    assign o_count    = r_tail - r_head;
    assign w_do_free  = i_free && !o_empty;

    // Indices below the head sit in the next lap of the ring.
    assign w_wrap = (i_restore_idx >= r_head[LW-1:0]) ?
                    r_head[LW] : ~r_head[LW];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_do_free)
                r_head <= r_head + (LW+1)'(1);
            if (i_restore)
                r_tail <= {w_wrap, i_restore_idx};
            else if (i_save)
                r_tail <= r_tail + (LW+1)'(1);
        end
    end

endmodule

// File: rtl/checkpoint_array.sv
// Ring of rename map snapshots: save on branch, restore on
// mispredict (one-cycle latency), free oldest-first on resolve.
module checkpoint_array #(
    parameter int CHECKPOINT_COUNT     = core_types_pkg::CHECKPOINT_COUNT,
    parameter int LOG_CHECKPOINT_COUNT = $clog2(CHECKPOINT_COUNT)
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               save_valid,
    input  core_types_pkg::map_table_snapshot_t save_map_table,
    output logic                               save_ready,
    output logic [LOG_CHECKPOINT_COUNT-1:0]    save_index,
    input  logic                               restore_request_valid,
    input  logic [LOG_CHECKPOINT_COUNT-1:0]    restore_request_index,
    output logic                               restore_valid,
    output core_types_pkg::map_table_snapshot_t restore_map_table,
    input  logic                               free_valid,
    output logic [LOG_CHECKPOINT_COUNT:0]      checkpoint_count
);

    import core_types_pkg::*;

    localparam int LW = LOG_CHECKPOINT_COUNT;

    map_table_snapshot_t r_entries [CHECKPOINT_COUNT];

    logic          w_save;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_head_idx;
    logic [LW-1:0] w_tail_idx;
    logic [LW:0]   w_count;

    assign save_ready       = !w_full && !restore_request_valid;
    assign w_save           = save_valid && save_ready;
    assign save_index       = w_tail_idx;
    assign checkpoint_count = w_count;

    checkpoint_ptr_ctrl #(
        .LW(LW)
    ) u_ptr (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_save       (w_save),
        .i_free       (free_valid),
        .i_restore    (restore_request_valid),
        .i_restore_idx(restore_request_index),
        .o_head_idx   (w_head_idx),
        .o_tail_idx   (w_tail_idx),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Snapshot storage carries no reset.
    always_ff @(posedge CLK) begin
        if (w_save)
            r_entries[w_tail_idx] <= save_map_table;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            restore_valid     <= 1'b0;
            restore_map_table <= '0;
        end else begin
            restore_valid <= restore_request_valid;
            if (restore_request_valid)
                restore_map_table <= r_entries[restore_request_index];
        end
    end

`ifndef SYNTHESIS
    logic [LW-1:0] w_rel;
    logic          w_occupied;

    assign w_rel      = restore_request_index - w_head_idx;
    assign w_occupied = ({1'b0, w_rel} < w_count);

    always_ff @(posedge CLK) begin
        if (!RST && restore_request_valid) begin
            assert (w_occupied)
                else $error("restore of unoccupied checkpoint");
            assert (!(free_valid && !w_empty &&
                      restore_request_index == w_head_idx))
                else $error("restore of head with free");
        end
    end
`endif

endmodule

// File: tb/tb_checkpoint_array.sv
// Randomised scoreboard bench for checkpoint_array against a
// queue-based model of the occupied checkpoints.
module tb_checkpoint_array;

    import core_types_pkg::*;

    typedef map_table_snapshot_t snap_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       save_valid = 1'b0;
    snap_t      save_map_table = '0;
    logic       save_ready;
    logic [2:0] save_index;
    logic       restore_request_valid = 1'b0;
    logic [2:0] restore_request_index = '0;
    logic       restore_valid;
    snap_t      restore_map_table;
    logic       free_valid = 1'b0;
    logic [3:0] checkpoint_count;

    checkpoint_array dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .save_valid           (save_valid),
        .save_map_table       (save_map_table),
        .save_ready           (save_ready),
        .save_index           (save_index),
        .restore_request_valid(restore_request_valid),
        .restore_request_index(restore_request_index),
        .restore_valid        (restore_valid),
        .restore_map_table    (restore_map_table),
        .free_valid           (free_valid),
        .checkpoint_count     (checkpoint_count)
    );

    always #5 CLK = ~CLK;

    int    n_checks = 0;
    int    n_fail   = 0;
    snap_t mq[$];
    int    mhead = 0;
    snap_t sb[$];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic snap_t rnd_snap();
        snap_t s;
        for (int i = 0; i < AR_COUNT; i++)
            s[i] = 6'($urandom);
        return s;
    endfunction

    always @(negedge CLK) begin
        if (!RST) begin
            chk("restore_valid", restore_valid, sb.size() != 0);
            if (restore_valid && sb.size() != 0)
                chk("restore_data", restore_map_table, sb.pop_front());
            else
                sb.delete();
        end
    end

    task automatic step(input logic sv, input snap_t d, input logic rr,
                        input int ridx, input logic fr);
        int    pre;
        bit    rdy;
        int    p;
        snap_t exp_d;
        @(negedge CLK);
        save_valid            = sv;
        save_map_table        = d;
        restore_request_valid = rr;
        restore_request_index = 3'(ridx);
        free_valid            = fr;
        #1;
        pre = mq.size();
        rdy = (pre < 8) && !rr;
        chk("save_ready", save_ready, rdy);
        chk("save_index", save_index, (mhead + pre) % 8);
        chk("count", checkpoint_count, pre);
        exp_d = '0;
        if (rr) begin
            p     = (ridx - mhead + 8) % 8;
            exp_d = mq[p];
            while (mq.size() > p)
                void'(mq.pop_back());
        end
        if (sv && rdy)
            mq.push_back(d);
        if (fr && pre > 0) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % 8;
        end
        @(posedge CLK);
        if (rr)
            sb.push_back(exp_d);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        snap_t d;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("reset_rv", restore_valid, 1'b0);
        chk("reset_rmt", restore_map_table, 256'd0);
        idle();

        for (int i = 0; i < 8; i++) begin
            d    = rnd_snap();
            d[0] = 6'(8'h10 + i);
            step(1'b1, d, 1'b0, 0, 1'b0);
        end
        step(1'b1, rnd_snap(), 1'b0, 0, 1'b0);
        step(1'b0, '0, 1'b1, 3, 1'b0);
        #1 chk("restore3_ar0", restore_map_table[0], 8'h13);
        idle();

        for (int i = 0; i < 5; i++)
            step(1'b1, rnd_snap(), 1'b0, 0, 1'b0);
        step(1'b1, rnd_snap(), 1'b0, 0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 0, 1'b1);
        step(1'b1, rnd_snap(), 1'b0, 0, 1'b1);
        step(1'b1, rnd_snap(), 1'b1, (mhead + 2) % 8, 1'b0);
        idle();

        step(1'b0, '0, 1'b1, mhead, 1'b0);
        #1 chk("rv_before_rst", restore_valid, 1'b1);
        sb.delete();
        #1 RST = 1'b1;
        #1 chk("rv_async_drop", restore_valid, 1'b0);
        chk("count_async", checkpoint_count, 4'd0);
        @(negedge CLK);
        save_valid            = 1'b0;
        restore_request_valid = 1'b0;
        free_valid            = 1'b0;
        mq.delete();
        mhead = 0;
        @(negedge CLK);
        RST = 1'b0;
        idle();

        repeat (6) step(1'b1, rnd_snap(), 1'b0, 0, 1'b0);
        repeat (5) step(1'b0, '0, 1'b0, 0, 1'b1);
        repeat (4) step(1'b1, rnd_snap(), 1'b0, 0, 1'b0);
        step(1'b0, '0, 1'b1, 0, 1'b0);
        idle();
        step(1'b1, rnd_snap(), 1'b0, 0, 1'b0);

        while (mq.size() > 0)
            step(1'b0, '0, 1'b0, 0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0, 0, 1'b1);
        idle();

        for (int n = 0; n < 300; n++) begin
            logic sv, rr, fr;
            int   ridx, p;
            sv   = ($urandom_range(0, 1) == 1);
            fr   = ($urandom_range(0, 2) == 0);
            rr   = 1'b0;
            ridx = 0;
            if (mq.size() > 0 && $urandom_range(0, 5) == 0) begin
                rr   = 1'b1;
                p    = $urandom_range(0, mq.size() - 1);
                ridx = (mhead + p) % 8;
                if (p == 0)
                    fr = 1'b0;
            end
            step(sv, rnd_snap(), rr, ridx, fr);
        end
        repeat (3) idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
